fpu_mul_arbiter: RTL
====================

Name: fpu_mul_arbiter

Overview:
- Round-robin scheduler that shares one combinational fpu_mul among N_REQ requesters, e.g. the twiddle-multiply lanes of the 8-point FFT butterfly stages.
- Accepts operand pairs over valid/ready handshakes and registers them onto the multiplier input bus.
- Tracks each issued operation's requester ID through a delay line matched to the multiplier latency.
- Returns each registered product tagged with its requester ID.

Parameters:
- SIZE_DATA, 32, operand/result width (IEEE-754 single).
- N_REQ, 4, number of requesters (2..8).
- SIZE_ID, 2, width of requester ID; must satisfy 2**SIZE_ID >= N_REQ.
- MUL_LAT, 0, cycles from o_mul_valid to a valid i_mul_result (0 = combinational fpu_mul; 1..4 allowed for a pipelined multiplier).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  N_REQ  per-requester operand-valid.
- i_req_a  in  N_REQ*SIZE_DATA  operand A; requester k occupies slice [k*SIZE_DATA +: SIZE_DATA].
- i_req_b  in  N_REQ*SIZE_DATA  operand B; same packing as i_req_a.
- o_req_ready  out  N_REQ  one-hot grant, doubles as ready.
- i_hold  in  1  stall; forces o_req_ready to 0.
- o_mul_a  out  SIZE_DATA  registered operand A to fpu_mul.
- o_mul_b  out  SIZE_DATA  registered operand B to fpu_mul.
- o_mul_valid  out  1  o_mul_a/o_mul_b carry a live operation.
- i_mul_result  in  SIZE_DATA  product from fpu_mul.
- o_rsp_valid  out  1  registered response valid.
- o_rsp_id  out  SIZE_ID  requester index of the response.
- o_rsp_data  out  SIZE_DATA  registered product.
- o_busy  out  1  any operation in flight.

Behaviour:
- Reset (async assert, sync deassert):
  - o_mul_a, o_mul_b, o_rsp_data = 0.
  - o_mul_valid, o_rsp_valid, o_busy = 0; o_rsp_id = 0.
  - Round-robin pointer last_grant = N_REQ-1, so requester 0 has top priority on the first request.
  - ID/valid delay line cleared.
- Grant (combinational):
  - If i_hold=1 or i_req_valid=0, o_req_ready=0.
  - Otherwise grant the first asserted i_req_valid searching from last_grant+1 upward, wrapping modulo N_REQ.
  - o_req_ready is exactly one-hot on the granted index; at most one handshake per cycle.
- Handshake at cycle T (i_req_valid[k] & o_req_ready[k]):
  - At edge T: o_mul_a/o_mul_b <= requester k's operands, o_mul_valid <= 1, last_grant <= k.
  - Stage-0 of the delay line <= {1, k}.
  - No handshake: o_mul_valid <= 0, o_mul_a/o_mul_b hold, last_grant holds.
- Delay line: MUL_LAT+1 stages of {valid, id}, shifted every cycle and never stalled.
- Response: when the last delay stage is valid, at the next edge o_rsp_valid <= 1, o_rsp_id <= id, o_rsp_data <= i_mul_result. Otherwise o_rsp_valid <= 0 and data/id hold.
- Latency: handshake at T gives o_mul_valid high in T+1 and o_rsp_valid high in T+2+MUL_LAT.
- Throughput: one operation per cycle. There is no response backpressure; requesters must sink o_rsp in the cycle it is valid.
- o_busy = OR of o_mul_valid and all delay-stage valids (combinational from registers).
- Boundary conditions:
  - A requester may hold i_req_valid while not granted; its operands must stay stable.
  - Simultaneous requests are served in strict rotation; a continuously requesting requester waits at most N_REQ-1 cycles.
  - Raising i_hold mid-stream blocks new grants only; in-flight operations drain and still respond.
  - Deasserting i_req_valid without a handshake is allowed and has no effect.
  - Reset mid-operation discards all in-flight operations with no response emitted, and restores the pointer.
- Special values (zero/inf/NaN) pass through unmodified; they are fpu_mul's responsibility.

Test Plan:
- Reset, MUL_LAT=0, requester 0 sends a=0x40000000, b=0x40400000 at T -> o_mul_valid in T+1; o_rsp_valid in T+2 with id=0, data=0x40C00000 (6.0).
- All 4 requesters valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; responses in the same order, one per cycle, 2 cycles after each grant.
- Requesters 1 and 3 valid, last_grant=1 -> grant 3, then 1; requester 2 asserting later is served before 1 is served again.
- i_hold=1 for 3 cycles while two operations are in flight -> o_req_ready=0 throughout; both responses still emerge; o_busy falls after the last one.
- MUL_LAT=2, requester 2 sends 0x3FC00000*0x3FC00000 -> o_rsp_valid exactly 4 cycles after the handshake, id=2, data=0x40100000 (2.25).
- Assert i_rst_n=0 with 2 operations in flight -> all outputs 0 immediately, no response after release, next grant goes to requester 0.

Source files
------------

// File: rtl/fpu_mul_arbiter_if.sv
// Requester/multiplier/response bundle for fpu_mul_arbiter.
// slave = arbiter side, master = the environment (requesters + fpu_mul).
interface fpu_mul_arbiter_if #(
  parameter int SIZE_DATA = 32,
  parameter int N_REQ     = 4,
  parameter int SIZE_ID   = 2
);
  logic [N_REQ-1:0]           i_req_valid;
  logic [N_REQ*SIZE_DATA-1:0] i_req_a;
  logic [N_REQ*SIZE_DATA-1:0] i_req_b;
  logic [N_REQ-1:0]           o_req_ready;
  logic                       i_hold;
  logic [SIZE_DATA-1:0]       o_mul_a;
  logic [SIZE_DATA-1:0]       o_mul_b;
  logic                       o_mul_valid;
  logic [SIZE_DATA-1:0]       i_mul_result;
  logic                       o_rsp_valid;
  logic [SIZE_ID-1:0]         o_rsp_id;
  logic [SIZE_DATA-1:0]       o_rsp_data;
  logic                       o_busy;

  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_hold, i_mul_result,
    output o_req_ready, o_mul_a, o_mul_b, o_mul_valid,
           o_rsp_valid, o_rsp_id, o_rsp_data, o_busy
  );

  modport master (
    output i_req_valid, i_req_a, i_req_b, i_hold, i_mul_result,
    input  o_req_ready, o_mul_a, o_mul_b, o_mul_valid,
           o_rsp_valid, o_rsp_id, o_rsp_data, o_busy
  );
endinterface

// File: rtl/fpu_mul_arbiter.sv
// Round-robin sharing of one fpu_mul among N_REQ requesters. Operands are
// registered onto the multiplier bus; the winner's ID rides a delay line
// matched to MUL_LAT so each registered product returns with its tag.
module fpu_mul_arbiter #(
  parameter int SIZE_DATA = 32,
  parameter int N_REQ     = 4,
  parameter int SIZE_ID   = 2,
  parameter int MUL_LAT   = 0
)(
  input  logic                i_clk,
  input  logic                i_rst_n,
  fpu_mul_arbiter_if.slave    bus
);
  localparam int STAGES = MUL_LAT;
  localparam logic [SIZE_ID-1:0] LAST_RST = SIZE_ID'(N_REQ - 1);

  logic [SIZE_ID-1:0]   last_grant;
  logic [SIZE_ID-1:0]   grant_id;
  logic [N_REQ-1:0]     grant;
  logic                 found;
  logic                 fire;
  logic [SIZE_DATA-1:0] sel_a, sel_b;
  logic [SIZE_DATA-1:0] mul_a, mul_b, rsp_data;
  logic                 mul_valid, rsp_valid;
  logic [SIZE_ID-1:0]   rsp_id;

  // ID delay line, one stage per multiplier cycle plus the operand register
  logic [STAGES:0]                vld_pipe;
  logic [STAGES:0][SIZE_ID-1:0]   id_pipe;

  // rotating-priority search, starting one past the previous winner
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!found && bus.i_req_valid[(int'(last_grant) + i) % N_REQ]) begin
        found    = 1'b1;
        grant[(int'(last_grant) + i) % N_REQ] = 1'b1;
        grant_id = SIZE_ID'((int'(last_grant) + i) % N_REQ);
      end
    end
  end

  assign fire            = found & ~bus.i_hold;
  assign bus.o_req_ready = bus.i_hold ? '0 : grant;

  // operand mux driven by the one-hot grant
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        sel_a = bus.i_req_a[k*SIZE_DATA +: SIZE_DATA];
        sel_b = bus.i_req_b[k*SIZE_DATA +: SIZE_DATA];
      end
    end
  end

  // multiplier input register and round-robin pointer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mul_a      <= '0;
      mul_b      <= '0;
      mul_valid  <= 1'b0;
      last_grant <= LAST_RST;
    end else begin
      mul_valid <= fire;
      if (fire) begin
        mul_a      <= sel_a;
        mul_b      <= sel_b;
        last_grant <= grant_id;
      end
    end
  end

  // tag delay line: shifts every cycle, never stalls
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[0] <= fire;
      id_pipe[0]  <= grant_id;
      for (int s = 1; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        id_pipe[s]  <= id_pipe[s-1];
      end
    end
  end

  // response register: capture the product when its tag reaches the end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= vld_pipe[STAGES];
      if (vld_pipe[STAGES]) begin
        rsp_id   <= id_pipe[STAGES];
        rsp_data <= bus.i_mul_result;
      end
    end
  end

  assign bus.o_mul_a     = mul_a;
  assign bus.o_mul_b     = mul_b;
  assign bus.o_mul_valid = mul_valid;
  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_id    = rsp_id;
  assign bus.o_rsp_data  = rsp_data;
  assign bus.o_busy      = mul_valid | (|vld_pipe);
endmodule
